// File: rtl/exec_pkg.sv
// Shared constants and types for the execute stage: opcodes, FSM state, iteration count.
// EXEC_DIV_EN enables the DIV state (DIVU/REMU); without it those opcodes are illegal.
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL
`ifdef EXEC_DIV_EN
    , ST_DIV
`endif
  } exec_state_t;

endpackage

// File: rtl/exec_unit_if.sv
// Instruction-in / write-back-out bundle between issue logic, exec_unit and the register file.
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready; op/rs_val/rt_val/rd are sampled only then.
interface exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [AW-1:0]    rd;
    logic             wb_wrt;
    logic [AW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             busy;
    logic             err;

    modport master (
        output in_valid, op, rs_val, rt_val, rd,
        input  in_ready, wb_wrt, wb_rd, wb_data, busy, err
    );

    modport slave (
        input  in_valid, op, rs_val, rt_val, rd,
        output in_ready, wb_wrt, wb_rd, wb_data, busy, err
    );
endinterface

// File: rtl/exec_unit_iter_muldiv.sv
// Iterative shift-add multiplier and (with EXEC_DIV_EN) restoring divider, one bit per cycle.
// done is high during the cycle whose rising edge performs the last iteration; result is that iteration's output.
module iter_muldiv
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div_mode,
    input  logic             rem_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(ITER);

    logic             run;
    logic [CW-1:0]    cnt;
    // acc: product or partial remainder; opa: multiplicand or divisor; opb: multiplier or dividend/quotient
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_n, opa_n, opb_n;

`ifdef EXEC_DIV_EN
    logic             div_q, rem_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             ge;
`else
    logic             unused_mode;
    assign unused_mode = div_mode | rem_mode;
`endif

    assign done = run && (cnt == CW'(ITER - 1));

    always_comb begin
        acc_n  = acc + (opb[0] ? opa : '0);
        opa_n  = opa << 1;
        opb_n  = opb >> 1;
        result = acc_n;
`ifdef EXEC_DIV_EN
        trial = {acc, opb[WIDTH-1]};
        diff  = trial[WIDTH-1:0] - opa;
        ge    = (trial >= {1'b0, opa});
        // A zero divisor always subtracts: quotient fills with ones, remainder ends as the dividend
        if (div_q) begin
            acc_n  = ge ? diff : trial[WIDTH-1:0];
            opa_n  = opa;
            opb_n  = {opb[WIDTH-2:0], ge};
            result = rem_q ? acc_n : opb_n;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
            opa <= '0;
            opb <= '0;
`ifdef EXEC_DIV_EN
            div_q <= 1'b0;
            rem_q <= 1'b0;
`endif
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            acc <= '0;
            opa <= b;
            opb <= a;
`ifdef EXEC_DIV_EN
            div_q <= div_mode;
            rem_q <= rem_mode;
`endif
        end else if (run) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            cnt <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end
endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus FSM sequencing iterative MUL (and DIVU/REMU under EXEC_DIV_EN).
// Write-back outputs are registered and hold their last value when wb_wrt is low.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    exec_unit_if.slave  bus,
    output exec_state_t dbg_state
);
    exec_state_t      state_q, state_d;
    logic             accept, op_single, op_mul, op_div, op_illegal, start;
    logic             md_done;
    logic [WIDTH-1:0] md_result, alu;
    logic [AW-1:0]    rd_q;
    logic             wb_wrt_q, err_q;
    logic [AW-1:0]    wb_rd_q;
    logic [WIDTH-1:0] wb_data_q;

    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.wb_wrt   = wb_wrt_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.err      = err_q;
    assign dbg_state    = state_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign op_single = (bus.op <= OP_SRL);
    assign op_mul    = (bus.op == OP_MUL);
`ifdef EXEC_DIV_EN
    assign op_div    = (bus.op == OP_DIVU) || (bus.op == OP_REMU);
`else
    assign op_div    = 1'b0;
`endif
    assign op_illegal = !(op_single || op_mul || op_div);
    assign start      = accept && (op_mul || op_div);

    always_comb begin
        alu = '0;
        case (bus.op)
            OP_ADD: alu = bus.rs_val + bus.rt_val;
            OP_SUB: alu = bus.rs_val - bus.rt_val;
            OP_AND: alu = bus.rs_val & bus.rt_val;
            OP_OR:  alu = bus.rs_val | bus.rt_val;
            OP_XOR: alu = bus.rs_val ^ bus.rt_val;
            OP_SLT: alu = {{(WIDTH-1){1'b0}}, ($signed(bus.rs_val) < $signed(bus.rt_val))};
            OP_SLL: alu = bus.rs_val << bus.rt_val[4:0];
            OP_SRL: alu = bus.rs_val >> bus.rt_val[4:0];
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && op_mul) state_d = ST_MUL;
`ifdef EXEC_DIV_EN
                if (accept && op_div) state_d = ST_DIV;
`endif
            end
            ST_MUL:  if (md_done) state_d = ST_IDLE;
`ifdef EXEC_DIV_EN
            ST_DIV:  if (md_done) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .div_mode (op_div),
        .rem_mode (bus.op == OP_REMU),
        .a        (bus.rs_val),
        .b        (bus.rt_val),
        .done     (md_done),
        .result   (md_result)
    );

    // Register 0 is hardwired zero: the op still runs but never strobes the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wrt_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            wb_wrt_q <= 1'b0;
            err_q    <= 1'b0;
            if (accept && op_single && (bus.rd != '0)) begin
                wb_wrt_q  <= 1'b1;
                wb_rd_q   <= bus.rd;
                wb_data_q <= alu;
            end
            if (accept && op_illegal) err_q <= 1'b1;
            if (start) rd_q <= bus.rd;
            if (md_done && (rd_q != '0)) begin
                wb_wrt_q  <= 1'b1;
                wb_rd_q   <= rd_q;
                wb_data_q <= md_result;
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: per-cycle compare against a result/timing model, plus literal checks.
// Build with EXEC_DIV_EN defined to exercise DIVU/REMU; otherwise op 9 is expected to flag err.
module tb_exec_unit;
  import exec_pkg::*;

  localparam int K_WRITE = 0;
  localparam int K_NONE  = 1;
  localparam int K_ERR   = 2;

  logic        clk;
  logic        rst_n;
  exec_state_t dbg_state;
  int          n_tests;
  int          n_fail;
  int          cyc;

  exec_unit_if #(.WIDTH(32), .AW(6)) bus ();

  exec_unit #(.WIDTH(32), .AW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model and scoreboard
  logic [31:0] exp_q[$];
  logic [5:0]  exp_rd_q[$];
  int          exp_due_q[$];
  int          exp_kind_q[$];
  int          ready_at;
  logic [5:0]  last_rd;
  logic [31:0] last_data;

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (o)
      4'd0: model = a + b;
      4'd1: model = a - b;
      4'd2: model = a & b;
      4'd3: model = a | b;
      4'd4: model = a ^ b;
      4'd5: model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: model = a << b[4:0];
      4'd7: model = a >> b[4:0];
      4'd8: begin p = {32'd0, a} * {32'd0, b}; model = p[31:0]; end
      4'd9: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd10: model = (b == 0) ? a : a % b;
      default: model = 32'd0;
    endcase
  endfunction

  function automatic bit is_multi(input logic [3:0] o);
`ifdef EXEC_DIV_EN
    is_multi = (o == 4'd8) || (o == 4'd9) || (o == 4'd10);
`else
    is_multi = (o == 4'd8);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    ready_at  = 0;
    last_rd   = '0;
    last_data = '0;
  end

  always @(negedge clk) begin
    int       k;
    bit       e_wrt, e_err, e_ready;
    logic [5:0]  e_rd;
    logic [31:0] e_data;
    if (!rst_n) begin
      chk("rst_wb_wrt", {31'd0, bus.wb_wrt}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_wb_rd", {26'd0, bus.wb_rd}, 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      exp_q.delete(); exp_rd_q.delete(); exp_due_q.delete(); exp_kind_q.delete();
      ready_at  = 0;
      last_rd   = '0;
      last_data = '0;
    end else begin
      e_ready = (cyc >= ready_at);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, e_ready});
      chk("busy", {31'd0, bus.busy}, {31'd0, !e_ready});
      e_wrt = 1'b0;
      e_err = 1'b0;
      if (exp_due_q.size() != 0 && exp_due_q[0] == cyc) begin
        void'(exp_due_q.pop_front());
        k = exp_kind_q.pop_front();
        e_rd   = exp_rd_q.pop_front();
        e_data = exp_q.pop_front();
        if (k == K_WRITE) begin
          e_wrt     = 1'b1;
          last_rd   = e_rd;
          last_data = e_data;
        end
        if (k == K_ERR) e_err = 1'b1;
      end
      chk("wb_wrt", {31'd0, bus.wb_wrt}, {31'd0, e_wrt});
      chk("err", {31'd0, bus.err}, {31'd0, e_err});
      chk("wb_rd", {26'd0, bus.wb_rd}, {26'd0, last_rd});
      chk("wb_data", bus.wb_data, last_data);
      // Predict the accept that happens at the coming rising edge
      if (bus.in_valid && e_ready) begin
        exp_q.push_back(model(bus.op, bus.rs_val, bus.rt_val));
        exp_rd_q.push_back(bus.rd);
        if (bus.op <= 4'd7 || is_multi(bus.op))
          exp_kind_q.push_back((bus.rd != 0) ? K_WRITE : K_NONE);
        else
          exp_kind_q.push_back(K_ERR);
        if (is_multi(bus.op)) begin
          exp_due_q.push_back(cyc + 33);
          ready_at = cyc + 33;
        end else begin
          exp_due_q.push_back(cyc + 1);
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [5:0] d);
    int n;
    n = 0;
    bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.rd = d; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: in_ready still 0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_wb(input string name, input logic [5:0] d, input logic [31:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.wb_wrt && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_wrt"}, {31'd0, bus.wb_wrt}, 32'd1);
    chk({name, "_rd"}, {26'd0, bus.wb_rd}, {26'd0, d});
    chk({name, "_data"}, bus.wb_data, v);
  endtask

  logic [3:0]  t_op[8];
  logic [31:0] t_a[8];
  logic [31:0] t_b[8];

  initial begin
    int lo;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0; bus.rd = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    issue(4'd0, 32'd7, 32'd5, 6'd12); idle();
    expect_wb("add", 6'd12, 32'd12);
    @(negedge clk);
    chk("add_strobe_once", {31'd0, bus.wb_wrt}, 32'd0);
    @(posedge clk); #1;

    issue(4'd1, 32'd3, 32'd5, 6'd1); idle();
    expect_wb("sub", 6'd1, 32'hFFFF_FFFE);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 6'd2); idle();
    expect_wb("slt", 6'd2, 32'd1);
    issue(4'd7, 32'h8000_0000, 32'd31, 6'd3); idle();
    expect_wb("srl", 6'd3, 32'd1);

    issue(4'd0, 32'd9, 32'd9, 6'd0); idle();
    repeat (3) begin
      @(negedge clk);
      chk("rd0_no_write", {31'd0, bus.wb_wrt}, 32'd0);
    end
    @(posedge clk); #1;

    // back-to-back single-cycle ops, checked by the model only
    t_op = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd5, 4'd7, 4'd1, 4'd0};
    t_a  = '{32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555, 32'h0000_0003, 32'd4, 32'hFFFF_0000, 32'd0, 32'hFFFF_FFFF};
    t_b  = '{32'h0FF0_FFFF, 32'h00F0_0010, 32'hFFFF_FFFF, 32'h0000_0024, 32'hFFFF_FFFE, 32'd36, 32'd1, 32'd2};
    for (int i = 0; i < 8; i++) issue(t_op[i], t_a[i], t_b[i], 6'(i + 20));
    idle();
    repeat (2) @(posedge clk); #1;

    // MUL with a following ADD held on the bus while busy
    issue(4'd8, 32'h0000_FFFF, 32'h0001_0001, 6'd5);
    bus.op = 4'd0; bus.rs_val = 32'd100; bus.rt_val = 32'd23; bus.rd = 6'd6;
    lo = 0;
    repeat (32) begin
      @(negedge clk);
      if (!bus.in_ready) lo++;
    end
    chk("mul_ready_low_cycles", lo, 32'd32);
    @(negedge clk);
    chk("mul_wrt", {31'd0, bus.wb_wrt}, 32'd1);
    chk("mul_rd", {26'd0, bus.wb_rd}, 32'd5);
    chk("mul_data", bus.wb_data, 32'hFFFF_FFFF);
    @(posedge clk); #1; idle();
    expect_wb("held_add", 6'd6, 32'd123);

    issue(4'd8, 32'd12345, 32'd6789, 6'd7); idle();
    expect_wb("mul2", 6'd7, 32'd83810205);

`ifdef EXEC_DIV_EN
    issue(4'd9, 32'd100, 32'd7, 6'd8); idle();
    expect_wb("divu", 6'd8, 32'd14);
    issue(4'd10, 32'd100, 32'd7, 6'd9); idle();
    expect_wb("remu", 6'd9, 32'd2);
    issue(4'd9, 32'd9, 32'd0, 6'd10); idle();
    expect_wb("divu_by0", 6'd10, 32'hFFFF_FFFF);
    issue(4'd10, 32'd9, 32'd0, 6'd11); idle();
    expect_wb("remu_by0", 6'd11, 32'd9);
    issue(4'd9, 32'hFFFF_FFFF, 32'h8000_0001, 6'd12); idle();
    expect_wb("divu_big", 6'd12, 32'd1);
`else
    issue(4'd9, 32'd100, 32'd7, 6'd8); idle();
    @(negedge clk);
    chk("div_off_err", {31'd0, bus.err}, 32'd1);
    chk("div_off_wrt", {31'd0, bus.wb_wrt}, 32'd0);
    @(posedge clk); #1;
`endif

    // reset during the 10th MUL iteration
    issue(4'd8, 32'd3, 32'd4, 6'd13); idle();
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (30) begin
      @(negedge clk);
      chk("midrst_no_wb", {31'd0, bus.wb_wrt}, 32'd0);
    end
    @(posedge clk); #1;
    issue(4'd0, 32'd1, 32'd2, 6'd4); idle();
    expect_wb("post_rst_add", 6'd4, 32'd3);

    // illegal opcode followed immediately by an ADD
    issue(4'd13, 32'd1, 32'd1, 6'd14);
    bus.op = 4'd0; bus.rs_val = 32'd40; bus.rt_val = 32'd2; bus.rd = 6'd15;
    @(negedge clk);
    chk("ill_err", {31'd0, bus.err}, 32'd1);
    chk("ill_wrt", {31'd0, bus.wb_wrt}, 32'd0);
    chk("ill_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1; idle();
    expect_wb("ill_next_add", 6'd15, 32'd42);
    @(negedge clk);
    chk("ill_err_once", {31'd0, bus.err}, 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_due_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage sitting directly downstream of the 64-entry register file: takes the two operand values read for an instruction, computes the result and hands back a write-back triple (write enable, destination, data) for the register file's write port. Single-cycle ALU operations complete in one clock; multiply (and optionally divide/remainder) run iteratively with a valid/ready handshake stalling the upstream issue logic.

## Interface
- WIDTH, 32, operand/result width
- AW, 6, register address width (64 registers)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present on op/rs_val/rt_val/rd
- in_ready  out  1  block can accept an instruction this cycle
- op  in  4  opcode (see Operation)
- rs_val  in  WIDTH  first operand (register file rs output)
- rt_val  in  WIDTH  second operand (register file rt output)
- rd  in  AW  destination register
- wb_wrt  out  1  write-back strobe to register file write enable
- wb_rd  out  AW  write-back destination
- wb_data  out  WIDTH  write-back data
- busy  out  1  multi-cycle operation in progress
- err  out  1  one-cycle pulse: illegal opcode accepted

## Operation
- Accept = in_valid && in_ready at a rising edge; inputs sampled only then.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL by rt_val[4:0], 7 SRL (logical) by rt_val[4:0], 8 MUL (low WIDTH bits of unsigned product), 9 DIVU quotient, 10 REMU remainder; 11–15 illegal.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- FSM states: IDLE, MUL, DIV. IDLE: in_ready=1. Accept of op 0–7 stays IDLE; op 8 -> MUL; op 9/10 -> DIV (or illegal without macro). MUL/DIV: in_ready=0, busy=1, 32-iteration counter; after last iteration -> IDLE.
- MUL: shift-add, one multiplier bit per cycle. DIV: restoring, one quotient bit per cycle; divide by zero gives quotient all-ones, remainder = rs_val.
- rd == 0: operation executes, wb_wrt suppressed (register 0 stays zero).
- Illegal opcode: no write-back, err pulses one cycle after accept, stays IDLE.
- Reset values: in_ready=1 (once rst_n high), busy=0, wb_wrt=0, wb_rd=0, wb_data=0, err=0, FSM IDLE, counter 0.

## Timing
- Single-cycle op accepted at edge N: wb_wrt=1 with wb_rd/wb_data valid for exactly cycle N+1; back-to-back accepts give back-to-back strobes.
- MUL/DIV accepted at edge N: busy/in_ready change at N+1; iterations at edges N+1..N+32; wb_wrt=1 during cycle N+33; in_ready=1 again from N+33, so next accept at edge N+33.
- wb_* are registered; stable across the falling edge where the register file commits.
- wb_wrt never high for more than one cycle per instruction; wb_data/wb_rd hold last value when wb_wrt=0.
- rst_n low mid-operation: in-flight op discarded, no write-back, all outputs to reset values immediately.

## Configuration
- EXEC_DIV_EN defined: ops 9/10 implemented via DIV state and divider datapath.
- Not defined: DIV state and divider absent; ops 9/10 treated as illegal (err pulse, no write-back).

## Structure
- Package exec_pkg: opcode constants, FSM state enum, iteration count constant (32).
- One sub-module: iter_muldiv (iterative shift-add multiplier / restoring divider, start/done handshake); ALU and FSM stay in exec_unit.

## Test plan
- ADD rs=7, rt=5, rd=12 -> one cycle later wb_wrt=1, wb_rd=12, wb_data=12; next cycle wb_wrt=0.
- SUB 3-5, SLT -1<1, SRL 0x80000000>>31 -> 0xFFFFFFFE, 1, 1; ADD to rd=0 -> wb_wrt stays 0.
- MUL 0xFFFF×0x10001 rd=5 -> in_ready low 32 cycles, wb_data=0xFFFFFFFF at accept+33; in_valid held meanwhile not accepted.
- DIVU 100/7 -> 14, REMU -> 2; DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9 (EXEC_DIV_EN); without macro op 9 -> err pulse, no write.
- rst_n asserted at iteration 10 of MUL -> no wb_wrt, in_ready=1 after release, fresh ADD completes normally.
- Opcode 13 -> err=1 one cycle, wb_wrt=0, following ADD accepted next cycle.
